stepmotor_mem_arbiter: RTL and testbench
========================================

# stepmotor_mem_arbiter

Two-master arbiter that shares the single-port 8192 x 32 on-chip RAM (`stepmotor_onchip_memory2_0`) between two Avalon-MM requesters, e.g. the Nios data master and the step-motor sequencer. It sits directly in front of the RAM's s1 port. It serialises accesses, drives the RAM command lines from registers and returns read data with `readdatavalid`. Arbitration is round-robin, or fixed-priority when compiled in.

## Interface
- `ADDR_W`, 13, word address width (RAM depth 2^ADDR_W)
- `DATA_W`, 32, data width; byteenable width `BE_W` = DATA_W/8
- `clk` in 1: sole clock, all logic rising-edge
- `reset` in 1: synchronous, active-high
- `m0_address` / `m1_address` in ADDR_W: word address
- `m0_byteenable` / `m1_byteenable` in BE_W: write byte lanes
- `m0_read` / `m1_read` in 1: read request
- `m0_write` / `m1_write` in 1: write request
- `m0_writedata` / `m1_writedata` in DATA_W: write data
- `m0_waitrequest` / `m1_waitrequest` out 1: high = command not accepted
- `m0_readdata` / `m1_readdata` out DATA_W: read data, qualified by `readdatavalid`
- `m0_readdatavalid` / `m1_readdatavalid` out 1: one-cycle read-data strobe
- `mem_address` out ADDR_W: to RAM `address`
- `mem_byteenable` out BE_W: to RAM `byteenable`
- `mem_chipselect` out 1: to RAM `chipselect`
- `mem_write` out 1: to RAM `write`
- `mem_writedata` out DATA_W: to RAM `writedata`
- `mem_clken` out 1: to RAM `clken`; constant 1
- `mem_reset_req` out 1: to RAM `reset_req`; constant 0
- `mem_readdata` in DATA_W: from RAM `readdata`; valid one cycle after the address is sampled

## Operation
- FSM states and transitions:
  - IDLE → ACCESS when any request is pending.
  - ACCESS → IDLE for a write.
  - ACCESS → RDATA for a read.
  - RDATA → IDLE.
- Arbitration is evaluated only in IDLE. A request is `mX_read | mX_write`.
- Round-robin: the master not granted last wins a tie. `last_grant` resets to 1, so m0 wins the first tie. A lone requester always wins.
- On grant, the winner's address, byteenable, writedata and command are registered onto the `mem_*` outputs. `mem_chipselect` = 1 and `mem_write` = the write command, both for the ACCESS cycle only.
- In ACCESS, the winner's `waitrequest` = 0 for exactly one cycle, and the command is accepted at the end of that cycle.
- `waitrequest` is 1 in all other cycles, including while idle.
- If read and write are asserted together, the access is treated as a write and the read is ignored.
- In RDATA:
  - `mX_readdata` = `mem_readdata` (combinational pass-through, broadcast to both masters).
  - The granted master's `readdatavalid` = 1.
- Masters must hold their command stable until `waitrequest` is low. The arbiter does not check this.
- `last_grant` updates on entry to ACCESS.

## Timing
- Reset values:
  - State = IDLE, `last_grant` = 1.
  - Both `waitrequest` = 1, both `readdatavalid` = 0.
  - `mem_chipselect` = 0, `mem_write` = 0.
  - `mem_address` = 0, `mem_byteenable` = 0, `mem_writedata` = 0.
- Write: request sampled in IDLE at cycle N. RAM write and `waitrequest` = 0 at N+1. Next arbitration at N+2, so 2 cycles per write.
- Read: request sampled at N. Address to RAM and `waitrequest` = 0 at N+1. `readdatavalid` and data at N+2. Next arbitration at N+3, so 3 cycles per read.
- A loser keeps `waitrequest` = 1 and is served at the next IDLE. Starvation is bounded to one access under round-robin.
- Reset asserted mid-access:
  - Next cycle is IDLE with reset values.
  - Any in-flight read produces no `readdatavalid`.
  - An in-flight write may or may not have committed.
- A request deasserted while waiting is dropped silently.

## Configuration
- `STEPMOTOR_ARB_FIXED_PRIO_EN`
  - Defined: m0 always wins simultaneous requests; `last_grant` is not used. m1 can starve under continuous m0 traffic.
  - Undefined (default): round-robin as above.

## Test plan
- Reset, then idle for 5 cycles → `waitrequest` = 1 on both masters, `readdatavalid` = 0 on both, `mem_chipselect` = 0.
- m0 write addr 0x0010, data 0xDEADBEEF, byteenable 0xF; then m0 read 0x0010 → write accepted at N+1; read gives `m0_readdatavalid` at its N+2 with 0xDEADBEEF.
- Byte-lane write: m1 writes 0x000000AA with byteenable 0x1 over 0x11223344 at addr 0x1FFF (top address); then m1 reads 0x1FFF → 0x112233AA.
- m0 and m1 read addrs 0x0001 / 0x0002 in the same cycle, held continuously for 4 grants:
  - Default build: grants alternate m0, m1, m0, m1.
  - With `STEPMOTOR_ARB_FIXED_PRIO_EN`: all 4 grants go to m0.
- Reset pulsed in the ACCESS cycle of an m1 read → no `m1_readdatavalid`; state is IDLE with reset values; m0 is granted first afterwards.
- m0 asserts read and write together at addr 0x0005 with data 0x5 → a single 2-cycle write occurs and no `readdatavalid` is produced.

Source files
------------

// File: rtl/stepmotor_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of the single-port on-chip RAM s1 port.
// Round-robin by default; define STEPMOTOR_ARB_FIXED_PRIO_EN for fixed m0 priority.
module stepmotor_mem_arbiter #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32,
   parameter int BE_W   = DATA_W / 8
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [ADDR_W-1:0] m0_address_i,
   input  logic [BE_W-1:0]   m0_byteenable_i,
   input  logic              m0_read_i,
   input  logic              m0_write_i,
   input  logic [DATA_W-1:0] m0_writedata_i,
   output logic              m0_waitrequest_o,
   output logic [DATA_W-1:0] m0_readdata_o,
   output logic              m0_readdatavalid_o,
   input  logic [ADDR_W-1:0] m1_address_i,
   input  logic [BE_W-1:0]   m1_byteenable_i,
   input  logic              m1_read_i,
   input  logic              m1_write_i,
   input  logic [DATA_W-1:0] m1_writedata_i,
   output logic              m1_waitrequest_o,
   output logic [DATA_W-1:0] m1_readdata_o,
   output logic              m1_readdatavalid_o,
   output logic [ADDR_W-1:0] mem_address_o,
   output logic [BE_W-1:0]   mem_byteenable_o,
   output logic              mem_chipselect_o,
   output logic              mem_write_o,
   output logic [DATA_W-1:0] mem_writedata_o,
   output logic              mem_clken_o,
   output logic              mem_reset_req_o,
   input  logic [DATA_W-1:0] mem_readdata_i
);

   // state  | meaning
   // IDLE   | arbitrate between pending requests
   // ACCESS | command on RAM, winner's waitrequest low
   // RDATA  | RAM read data returned, winner's readdatavalid high
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RDATA  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                grant_q, grant_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [BE_W-1:0]     be_q, be_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                cs_q, cs_d;
   logic                we_q, we_d;
   logic                req0, req1, pick1;

   assign req0 = m0_read_i | m0_write_i;
   assign req1 = m1_read_i | m1_write_i;

`ifdef STEPMOTOR_ARB_FIXED_PRIO_EN
   assign pick1 = req1 & ~req0;
`else
   // last_grant_q = 1 means m1 was served last, so m0 wins the next tie
   logic last_grant_q, last_grant_d;
   assign pick1 = req1 & (~req0 | ~last_grant_q);
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      cs_d    = 1'b0;
      we_d    = 1'b0;
`ifndef STEPMOTOR_ARB_FIXED_PRIO_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req0 | req1) begin
               state_d = S_ACCESS;
               grant_d = pick1;
               addr_d  = pick1 ? m1_address_i    : m0_address_i;
               be_d    = pick1 ? m1_byteenable_i : m0_byteenable_i;
               wdata_d = pick1 ? m1_writedata_i  : m0_writedata_i;
               cs_d    = 1'b1;
               // a simultaneous read+write is a write
               we_d    = pick1 ? m1_write_i      : m0_write_i;
`ifndef STEPMOTOR_ARB_FIXED_PRIO_EN
               last_grant_d = pick1;
`endif
            end
         end
         S_ACCESS: state_d = we_q ? S_IDLE : S_RDATA;
         S_RDATA:  state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         grant_q <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         cs_q    <= 1'b0;
         we_q    <= 1'b0;
`ifndef STEPMOTOR_ARB_FIXED_PRIO_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         cs_q    <= cs_d;
         we_q    <= we_d;
`ifndef STEPMOTOR_ARB_FIXED_PRIO_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign m0_waitrequest_o   = ~((state_q == S_ACCESS) & ~grant_q);
   assign m1_waitrequest_o   = ~((state_q == S_ACCESS) &  grant_q);
   assign m0_readdatavalid_o = (state_q == S_RDATA) & ~grant_q;
   assign m1_readdatavalid_o = (state_q == S_RDATA) &  grant_q;
   assign m0_readdata_o      = mem_readdata_i;
   assign m1_readdata_o      = mem_readdata_i;

   assign mem_address_o    = addr_q;
   assign mem_byteenable_o = be_q;
   assign mem_writedata_o  = wdata_q;
   assign mem_chipselect_o = cs_q;
   assign mem_write_o      = we_q;
   assign mem_clken_o      = 1'b1;
   assign mem_reset_req_o  = 1'b0;

endmodule

// File: tb/tb_stepmotor_mem_arbiter.sv
// Scoreboard bench for stepmotor_mem_arbiter with a behavioural 8192 x 32 RAM.
// Grant order expectations follow STEPMOTOR_ARB_FIXED_PRIO_EN when defined.
module tb_stepmotor_mem_arbiter;
   localparam int ADDR_W = 13;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic [ADDR_W-1:0] m0_address, m1_address;
   logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
   logic              m0_read, m0_write, m1_read, m1_write;
   logic [DATA_W-1:0] m0_writedata, m1_writedata;
   logic              m0_waitrequest, m1_waitrequest;
   logic [DATA_W-1:0] m0_readdata, m1_readdata;
   logic              m0_readdatavalid, m1_readdatavalid;
   logic [ADDR_W-1:0] mem_address;
   logic [BE_W-1:0]   mem_byteenable;
   logic              mem_chipselect, mem_write, mem_clken, mem_reset_req;
   logic [DATA_W-1:0] mem_writedata;
   logic [DATA_W-1:0] mem_readdata;

   stepmotor_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
      .clk_i(clk), .reset_i(reset),
      .m0_address_i(m0_address), .m0_byteenable_i(m0_byteenable),
      .m0_read_i(m0_read), .m0_write_i(m0_write), .m0_writedata_i(m0_writedata),
      .m0_waitrequest_o(m0_waitrequest), .m0_readdata_o(m0_readdata),
      .m0_readdatavalid_o(m0_readdatavalid),
      .m1_address_i(m1_address), .m1_byteenable_i(m1_byteenable),
      .m1_read_i(m1_read), .m1_write_i(m1_write), .m1_writedata_i(m1_writedata),
      .m1_waitrequest_o(m1_waitrequest), .m1_readdata_o(m1_readdata),
      .m1_readdatavalid_o(m1_readdatavalid),
      .mem_address_o(mem_address), .mem_byteenable_o(mem_byteenable),
      .mem_chipselect_o(mem_chipselect), .mem_write_o(mem_write),
      .mem_writedata_o(mem_writedata), .mem_clken_o(mem_clken),
      .mem_reset_req_o(mem_reset_req), .mem_readdata_i(mem_readdata)
   );

   // RAM model: one-cycle registered read, byte-lane writes
   logic [DATA_W-1:0] ram [0:8191];
   always @(posedge clk) begin
      if (mem_clken && mem_chipselect) begin
         if (mem_write)
            for (int b = 0; b < BE_W; b++)
               if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
         mem_readdata <= ram[mem_address];
      end
   end

   typedef struct {int m; bit wr; logic [ADDR_W-1:0] addr;} acc_t;
   typedef struct {int m; logic [DATA_W-1:0] data;} rd_t;
   acc_t exp_acc[$];
   rd_t  exp_rd[$];
   int   grant_log[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   last_rd_acc_cyc = -10;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: pops expectations whenever a grant or read-data strobe is seen
   always @(negedge clk) begin
      acc_t a;
      rd_t  r;
      int   m;
      if (!m0_waitrequest || !m1_waitrequest) begin
         m = !m0_waitrequest ? 0 : 1;
         grant_log.push_back(cyc);
         check("single_grant", 32'(!m0_waitrequest && !m1_waitrequest), 32'(0));
         if (exp_acc.size() == 0) check("unexpected_grant", 32'(m), 32'hFFFF_FFFF);
         else begin
            a = exp_acc.pop_front();
            check("grant_master", 32'(m), 32'(a.m));
            check("grant_chipselect", 32'(mem_chipselect), 32'(1));
            check("grant_write", 32'(mem_write), 32'(a.wr));
            check("grant_address", 32'(mem_address), 32'(a.addr));
            if (!a.wr) last_rd_acc_cyc = cyc;
         end
      end
      if (m0_readdatavalid || m1_readdatavalid) begin
         m = m0_readdatavalid ? 0 : 1;
         check("single_rdv", 32'(m0_readdatavalid && m1_readdatavalid), 32'(0));
         if (exp_rd.size() == 0) check("unexpected_rdv", 32'(m), 32'hFFFF_FFFF);
         else begin
            r = exp_rd.pop_front();
            check("rdv_master", 32'(m), 32'(r.m));
            check("rdv_latency", 32'(cyc), 32'(last_rd_acc_cyc + 1));
            check("rdv_data", (m == 0) ? m0_readdata : m1_readdata, r.data);
         end
      end
   end

   task automatic drive(input int m, input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input logic [BE_W-1:0] be);
      if (m == 0) begin
         m0_read = rd; m0_write = wr; m0_address = addr; m0_writedata = data; m0_byteenable = be;
      end else begin
         m1_read = rd; m1_write = wr; m1_address = addr; m1_writedata = data; m1_byteenable = be;
      end
   endtask

   // hold the command until waitrequest is seen low, then release after the accepting edge
   task automatic do_access(input int m, input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] data, input logic [BE_W-1:0] be);
      int n = 0;
      drive(m, rd, wr, addr, data, be);
      do begin
         @(negedge clk);
         n++;
      end while (((m == 0) ? m0_waitrequest : m1_waitrequest) && n < 100);
      if (n >= 100) begin
         n_checks++;
         n_fail++;
         $display("FAIL grant_timeout: m%0d still waiting after %0d cycles", m, n);
      end
      @(posedge clk);
      #1 drive(m, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic issue(input int m, input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input logic [BE_W-1:0] be,
                        input logic [DATA_W-1:0] exp_data);
      exp_acc.push_back('{m: m, wr: wr, addr: addr});
      if (rd && !wr) exp_rd.push_back('{m: m, data: exp_data});
      do_access(m, rd, wr, addr, data, be);
   endtask

   initial begin
      int n0;
      int wait_n;
      for (int i = 0; i < 8192; i++) ram[i] = '0;
      mem_readdata = '0;
      reset = 1'b1;
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0, '0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // idle after reset
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_wait", 32'({m0_waitrequest, m1_waitrequest}), 32'(2'b11));
         check("idle_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'(0));
         check("idle_cs", 32'({mem_chipselect, mem_write}), 32'(0));
      end
      check("idle_regs", 32'(mem_address) | 32'(mem_byteenable) | mem_writedata, 32'(0));
      check("const_ctl", 32'({mem_clken, mem_reset_req}), 32'(2'b10));
      @(posedge clk);
      #1;

      issue(0, 1'b0, 1'b1, 13'h0010, 32'hDEADBEEF, 4'hF, '0);
      issue(0, 1'b1, 1'b0, 13'h0010, '0, 4'hF, 32'hDEADBEEF);

      // byte-lane write at the top address
      issue(1, 1'b0, 1'b1, 13'h1FFF, 32'h11223344, 4'hF, '0);
      issue(1, 1'b0, 1'b1, 13'h1FFF, 32'h000000AA, 4'h1, '0);
      issue(1, 1'b1, 1'b0, 13'h1FFF, '0, 4'hF, 32'h112233AA);

      // preload by m1 so m0 is favoured at the next tie
      issue(1, 1'b0, 1'b1, 13'h0001, 32'h11111111, 4'hF, '0);
      issue(1, 1'b0, 1'b1, 13'h0002, 32'h22222222, 4'hF, '0);

      // contention: both masters reading continuously
`ifdef STEPMOTOR_ARB_FIXED_PRIO_EN
      n0 = 4;
      for (int i = 0; i < 4; i++) begin
         exp_acc.push_back('{m: 0, wr: 1'b0, addr: 13'h0001});
         exp_rd.push_back('{m: 0, data: 32'h11111111});
      end
      for (int i = 0; i < 2; i++) begin
         exp_acc.push_back('{m: 1, wr: 1'b0, addr: 13'h0002});
         exp_rd.push_back('{m: 1, data: 32'h22222222});
      end
`else
      n0 = 2;
      for (int i = 0; i < 2; i++) begin
         exp_acc.push_back('{m: 0, wr: 1'b0, addr: 13'h0001});
         exp_rd.push_back('{m: 0, data: 32'h11111111});
         exp_acc.push_back('{m: 1, wr: 1'b0, addr: 13'h0002});
         exp_rd.push_back('{m: 1, data: 32'h22222222});
      end
`endif
      grant_log.delete();
      fork
         for (int i = 0; i < n0; i++) do_access(0, 1'b1, 1'b0, 13'h0001, '0, 4'hF);
         for (int i = 0; i < 2; i++)  do_access(1, 1'b1, 1'b0, 13'h0002, '0, 4'hF);
      join
      check("read_spacing", 32'(grant_log[1] - grant_log[0]), 32'(3));

      // reset pulsed during the ACCESS cycle of an m1 read
      exp_acc.push_back('{m: 1, wr: 1'b0, addr: 13'h0003});
      drive(1, 1'b1, 1'b0, 13'h0003, '0, 4'hF);
      wait_n = 0;
      do begin
         @(negedge clk);
         wait_n++;
      end while (m1_waitrequest && wait_n < 100);
      check("rst_grant_seen", 32'(m1_waitrequest), 32'(0));
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      drive(1, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      check("rst_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'(0));
      check("rst_wait", 32'({m0_waitrequest, m1_waitrequest}), 32'(2'b11));
      check("rst_cs", 32'({mem_chipselect, mem_write}), 32'(0));
      check("rst_regs", 32'(mem_address) | 32'(mem_byteenable) | mem_writedata, 32'(0));
      @(posedge clk);
      #1;

      // simultaneous writes after reset: m0 first, 2 cycles per write
      exp_acc.push_back('{m: 0, wr: 1'b1, addr: 13'h0006});
      exp_acc.push_back('{m: 1, wr: 1'b1, addr: 13'h0007});
      grant_log.delete();
      fork
         do_access(0, 1'b0, 1'b1, 13'h0006, 32'h66666666, 4'hF);
         do_access(1, 1'b0, 1'b1, 13'h0007, 32'h77777777, 4'hF);
      join
      check("write_spacing", 32'(grant_log[1] - grant_log[0]), 32'(2));
      issue(1, 1'b1, 1'b0, 13'h0006, '0, 4'hF, 32'h66666666);
      issue(0, 1'b1, 1'b0, 13'h0007, '0, 4'hF, 32'h77777777);

      // read and write together: a write, no read data
      issue(0, 1'b1, 1'b1, 13'h0005, 32'h00000005, 4'hF, '0);
      issue(0, 1'b1, 1'b0, 13'h0005, '0, 4'hF, 32'h00000005);

      wait_n = 0;
      while ((exp_acc.size() != 0 || exp_rd.size() != 0) && wait_n < 20) begin
         @(negedge clk);
         wait_n++;
      end
      repeat (4) @(negedge clk);
      check("acc_drained", 32'(exp_acc.size()), 32'(0));
      check("rd_drained", 32'(exp_rd.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, got %0d cycles", cyc);
      $fatal(1, "watchdog");
   end

endmodule
